// File: rtl/rf_mem_arb_if.sv
// rtl/rf_mem_arb_if.sv - requester and data-memory signal bundle for rf_mem_arb
//
// Requester side:
//   fill_req[k], spill_req[k]   read / write-back request from register-file entry k
//   req_addr[k], spill_data[k]  entry k's address (tag) and write-back value
//   done[k], done_is_fill       one-cycle completion pulse and the kind of operation completed
//   rdata                       fill data, valid while done is high
// Memory side:
//   mem_req, mem_we             request (held until mem_ack) and write enable
//   mem_addr, mem_wdata         address and write data
//   mem_ack, mem_rdata          accept / read-data-valid strobe and read data
//
// The master modport is the arbiter; the slave modport is the requester plus memory environment.
interface rf_mem_arb_if #(
    parameter int NCORES = 4
);
    logic [NCORES-1:0]       fill_req;
    logic [NCORES-1:0]       spill_req;
    logic [NCORES-1:0][15:0] req_addr;
    logic [NCORES-1:0][15:0] spill_data;
    logic [NCORES-1:0]       done;
    logic                    done_is_fill;
    logic [15:0]             rdata;
    logic                    mem_req;
    logic                    mem_we;
    logic [15:0]             mem_addr;
    logic [15:0]             mem_wdata;
    logic                    mem_ack;
    logic [15:0]             mem_rdata;

    modport master (
        input  fill_req, spill_req, req_addr, spill_data, mem_ack, mem_rdata,
        output done, done_is_fill, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output fill_req, spill_req, req_addr, spill_data, mem_ack, mem_rdata,
        input  done, done_is_fill, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rf_mem_arb.sv
// rtl/rf_mem_arb.sv - round-robin fill/spill arbiter sharing one 16-bit data-memory port
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  rf_mem_arb_if.master: per-entry fill/spill requests with address and data,
//        per-entry done pulses with fill data, and the single memory request/ack port.
//
// One operation is in flight at a time: IDLE picks a winner, BUSY holds the memory
// request until mem_ack, RESP pulses done for one cycle and advances the round-robin pointer.
module rf_mem_arb #(
    parameter int NCORES = 4
) (
    input  logic         clk,
    input  logic         rst,
    rf_mem_arb_if.master bus
);
    localparam int            PW   = $clog2(NCORES);
    localparam logic [PW-1:0] LAST = PW'(NCORES - 1);
    localparam logic [PW:0]   NC_W = (PW + 1)'(NCORES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic          we_q, we_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;

    logic [NCORES-1:0] cand;
    logic              found;
    logic [PW-1:0]     pick;
    logic [PW:0]       idx_ext;
    logic [PW-1:0]     idx;

    // First candidate at or above rr_ptr, wrapping explicitly so that
    // non-power-of-two entry counts never visit an out-of-range index.
    always_comb begin : arbitrate
        cand    = bus.fill_req | bus.spill_req;
        found   = 1'b0;
        pick    = rr_ptr_q;
        idx_ext = '0;
        idx     = '0;
        for (int i = 0; i < NCORES; i++) begin
            idx_ext = {1'b0, rr_ptr_q} + (PW + 1)'(i);
            if (idx_ext >= NC_W) begin
                idx_ext = idx_ext - NC_W;
            end
            idx = idx_ext[PW-1:0];
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    // A pending spill goes first so an evicted dirty value reaches
                    // memory before the same entry's refill reads it back.
                    we_d    = bus.spill_req[pick];
                    addr_d  = bus.req_addr[pick];
                    wdata_d = bus.spill_data[pick];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                rr_ptr_d = (win_q == LAST) ? '0 : win_q + PW'(1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Every output comes from registers; mem_req is a state decode, so the
    // asynchronous reset of state_q drops it without waiting for a clock.
    always_comb begin : done_decode
        bus.done = '0;
        if (state_q == RESP) begin
            bus.done[win_q] = 1'b1;
        end
    end

    assign bus.done_is_fill = (state_q == RESP) && !we_q;
    assign bus.rdata        = rdata_q;
    assign bus.mem_req      = (state_q == BUSY);
    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
endmodule

// File: tb/tb_rf_mem_arb.sv
// tb/tb_rf_mem_arb.sv - self-checking bench for rf_mem_arb
module tb_rf_mem_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rf_mem_arb_if #(.NCORES(4)) bus ();

    rf_mem_arb #(.NCORES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       fill;
        logic [3:0]       spill;
        logic [3:0][15:0] addr;
        logic [3:0][15:0] data;
        int               wt;
        logic [15:0]      mrd;
        logic [3:0]       e_done;
        logic             e_we;
        logic [15:0]      e_addr;
        logic [15:0]      e_wdata;
        logic             e_fill;
        logic [15:0]      e_rdata;
    } vec_t;

    vec_t vecs [7];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit auto_mem = 1'b0;
    int auto_wait = 0;
    int wait_cnt  = 0;
    logic [15:0] mem_arr [logic [15:0]];

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 16'hA5C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Zero-latency-configurable memory used by the directed sequences.
    task automatic mem_respond();
        if (bus.mem_req) begin
            if (wait_cnt >= auto_wait) begin
                bus.mem_ack = 1'b1;
                if (bus.mem_we) begin
                    mem_arr[bus.mem_addr] = bus.mem_wdata;
                    bus.mem_rdata = 16'h0BAD;
                end else begin
                    bus.mem_rdata = mem_read(bus.mem_addr);
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
            wait_cnt++;
        end else begin
            wait_cnt    = 0;
            bus.mem_ack = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_mem) mem_respond();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.fill_req   = '0;
        bus.spill_req  = '0;
        bus.req_addr   = '0;
        bus.spill_data = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        tick();
        tick();
        rst      = 1'b0;
        wait_cnt = 0;
    endtask

    task automatic wait_done(output logic [3:0] d, output int at, output logic we,
                             output logic [15:0] a, output logic [15:0] wd);
        d = '0; at = -1; we = 1'b0; a = '0; wd = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.mem_req) begin
                we = bus.mem_we; a = bus.mem_addr; wd = bus.mem_wdata;
            end
            if (bus.done != 4'b0) begin
                d  = bus.done;
                at = cyc;
                return;
            end
        end
        n_checks++;
        n_err++;
        $display("FAIL done_timeout: got no done in 40 cycles, required one");
    endtask

    logic [3:0]  d;
    int          at, last_at;
    logic        we;
    logic [15:0] a, wd, exp_r;
    int          ndone;
    int          rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 0};

    // Random-phase model state
    int          m_rr, m_win, m_free_at, m_busy_from, m_busy_to, m_done_at;
    bit          m_spill, in_busy;
    logic [15:0] m_addr, m_wdata, m_fill_val, m_rdata;
    logic [3:0]  m_cand;
    logic [1:0]  r;
    int          kk;
    bit          got;

    initial begin
        // fill, spill, addr[3..0], data[3..0], wait, mem_rdata,
        // exp done, exp we, exp addr, exp wdata, exp is_fill, exp rdata
        vecs[0] = '{4'b0010, 4'b0000, {16'h0, 16'h0, 16'h1234, 16'h0}, {16'h0, 16'h0, 16'h0, 16'h0},
                    0, 16'hBEEF, 4'b0010, 1'b0, 16'h1234, 16'h0, 1'b1, 16'hBEEF};
        vecs[1] = '{4'b1000, 4'b0001, {16'h0300, 16'h0, 16'h0, 16'h0010}, {16'h0, 16'h0, 16'h0, 16'h0A0A},
                    2, 16'h3333, 4'b1000, 1'b0, 16'h0300, 16'h0, 1'b1, 16'h3333};
        vecs[2] = '{4'b0000, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0040}, {16'h0, 16'h0, 16'h0, 16'h00AA},
                    1, 16'hFFFF, 4'b0001, 1'b1, 16'h0040, 16'h00AA, 1'b0, 16'h3333};
        vecs[3] = '{4'b0001, 4'b0100, {16'h0, 16'h2222, 16'h0, 16'h0050}, {16'h0, 16'h5555, 16'h0, 16'h0},
                    0, 16'h1111, 4'b0100, 1'b1, 16'h2222, 16'h5555, 1'b0, 16'h3333};
        vecs[4] = '{4'b0011, 4'b0000, {16'h0, 16'h0, 16'h0101, 16'h0040}, {16'h0, 16'h0, 16'h0, 16'h0},
                    3, 16'hC0DE, 4'b0001, 1'b0, 16'h0040, 16'h0, 1'b1, 16'hC0DE};
        vecs[5] = '{4'b0010, 4'b0010, {16'h0, 16'h0, 16'h0777, 16'h0}, {16'h0, 16'h0, 16'h7070, 16'h0},
                    0, 16'h1234, 4'b0010, 1'b1, 16'h0777, 16'h7070, 1'b0, 16'hC0DE};
        vecs[6] = '{4'b0101, 4'b0000, {16'h0, 16'hFFFF, 16'h0, 16'h0060}, {16'h0, 16'h0, 16'h0, 16'h0},
                    0, 16'h0001, 4'b0100, 1'b0, 16'hFFFF, 16'h0, 1'b1, 16'h0001};

        do_reset();
        chk("reset_mem_req", 32'(bus.mem_req), 0);
        chk("reset_mem_we", 32'(bus.mem_we), 0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 0);
        chk("reset_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_done_is_fill", 32'(bus.done_is_fill), 0);
        chk("reset_rdata", 32'(bus.rdata), 0);

        // Table vectors: one transaction each, round-robin pointer carried between rows.
        for (int i = 0; i < 7; i++) begin
            bus.fill_req   = vecs[i].fill;
            bus.spill_req  = vecs[i].spill;
            bus.req_addr   = vecs[i].addr;
            bus.spill_data = vecs[i].data;
            bus.mem_ack    = 1'b0;
            tick();
            chk("vec_mem_req", 32'(bus.mem_req), 1);
            chk("vec_mem_we", 32'(bus.mem_we), 32'(vecs[i].e_we));
            chk("vec_mem_addr", 32'(bus.mem_addr), 32'(vecs[i].e_addr));
            if (vecs[i].e_we) chk("vec_mem_wdata", 32'(bus.mem_wdata), 32'(vecs[i].e_wdata));
            chk("vec_no_early_done", 32'(bus.done), 0);
            for (int w = 0; w < vecs[i].wt; w++) begin
                tick();
                chk("vec_wait_req", 32'(bus.mem_req), 1);
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = vecs[i].mrd;
            tick();
            bus.mem_ack = 1'b0;
            chk("vec_done", 32'(bus.done), 32'(vecs[i].e_done));
            chk("vec_done_is_fill", 32'(bus.done_is_fill), 32'(vecs[i].e_fill));
            chk("vec_rdata", 32'(bus.rdata), 32'(vecs[i].e_rdata));
            bus.fill_req  = '0;
            bus.spill_req = '0;
            tick();
            chk("vec_idle_done", 32'(bus.done), 0);
            chk("vec_idle_req", 32'(bus.mem_req), 0);
        end

        // Round robin with all fills held, zero-wait memory; entry 3 leaves after its done.
        do_reset();
        auto_mem      = 1'b1;
        auto_wait     = 0;
        bus.req_addr  = {16'h3000, 16'h2000, 16'h1000, 16'h0000};
        bus.fill_req  = 4'b1111;
        last_at       = 0;
        for (int k = 0; k < 8; k++) begin
            wait_done(d, at, we, a, wd);
            chk("rr_order", 32'(d), 32'd1 << rr_exp[k]);
            if (k > 0) chk("rr_spacing", 32'(at - last_at), 3);
            last_at = at;
            if (k == 3) bus.fill_req[3] = 1'b0;
        end
        bus.fill_req = '0;

        // Spill and fill together on entry 2: write first, then read back the new value.
        bus.spill_req      = 4'b0100;
        bus.fill_req       = 4'b0100;
        bus.req_addr[2]    = 16'h0040;
        bus.spill_data[2]  = 16'h00AA;
        wait_done(d, at, we, a, wd);
        chk("sf_first_done", 32'(d), 32'b0100);
        chk("sf_first_is_fill", 32'(bus.done_is_fill), 0);
        chk("sf_first_we", 32'(we), 1);
        chk("sf_first_addr", 32'(a), 16'h0040);
        chk("sf_first_wdata", 32'(wd), 16'h00AA);
        bus.spill_req[2] = 1'b0;
        wait_done(d, at, we, a, wd);
        chk("sf_second_done", 32'(d), 32'b0100);
        chk("sf_second_is_fill", 32'(bus.done_is_fill), 1);
        chk("sf_second_we", 32'(we), 0);
        chk("sf_second_rdata", 32'(bus.rdata), 16'h00AA);
        bus.fill_req = '0;

        // Five wait states while the requester side keeps changing.
        auto_mem = 1'b0;
        tick();
        bus.spill_req     = 4'b0010;
        bus.req_addr[1]   = 16'h0111;
        bus.spill_data[1] = 16'h1111;
        bus.mem_ack       = 1'b0;
        tick();
        for (int b = 1; b <= 6; b++) begin
            chk("ws_mem_req", 32'(bus.mem_req), 1);
            chk("ws_mem_we", 32'(bus.mem_we), 1);
            chk("ws_mem_addr", 32'(bus.mem_addr), 16'h0111);
            chk("ws_mem_wdata", 32'(bus.mem_wdata), 16'h1111);
            chk("ws_no_done", 32'(bus.done), 0);
            bus.spill_data[1] = 16'($urandom);
            bus.fill_req      = bus.fill_req | 4'b1101;
            bus.req_addr[3]   = 16'($urandom);
            bus.mem_ack       = (b == 6);
            bus.mem_rdata     = 16'($urandom);
            tick();
        end
        bus.mem_ack = 1'b0;
        chk("ws_done", 32'(bus.done), 32'b0010);
        chk("ws_done_is_fill", 32'(bus.done_is_fill), 0);
        bus.fill_req  = '0;
        bus.spill_req = '0;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done != 4'b0) ndone++;
        end
        chk("ws_single_done", 32'(ndone), 0);

        // Reset during the third wait cycle of a fill.
        bus.fill_req    = 4'b0010;
        bus.req_addr[1] = 16'h0999;
        tick();
        tick();
        tick();
        chk("rb_pre_req", 32'(bus.mem_req), 1);
        #2;
        rst             = 1'b1;
        bus.fill_req    = 4'b1001;
        bus.req_addr[0] = 16'h0A00;
        bus.req_addr[3] = 16'h0303;
        #1;
        chk("rb_async_mem_req", 32'(bus.mem_req), 0);
        chk("rb_async_done", 32'(bus.done), 0);
        tick();
        chk("rb_hold_done", 32'(bus.done), 0);
        chk("rb_hold_req", 32'(bus.mem_req), 0);
        rst       = 1'b0;
        auto_mem  = 1'b1;
        auto_wait = 1;
        wait_done(d, at, we, a, wd);
        chk("rb_first_entry", 32'(d), 32'b0001);
        chk("rb_first_addr", 32'(a), 16'h0A00);
        bus.fill_req[0] = 1'b0;
        wait_done(d, at, we, a, wd);
        chk("rb_second_entry", 32'(d), 32'b1000);
        chk("rb_second_rdata", 32'(bus.rdata), 32'(mem_read(16'h0303)));
        bus.fill_req = '0;

        // Stray acks in IDLE and RESP.
        auto_mem = 1'b0;
        exp_r    = mem_read(16'h0303);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        tick();
        chk("stray_idle_req", 32'(bus.mem_req), 0);
        chk("stray_idle_done", 32'(bus.done), 0);
        chk("stray_idle_rdata", 32'(bus.rdata), 32'(exp_r));
        bus.mem_ack     = 1'b0;
        bus.fill_req    = 4'b0100;
        bus.req_addr[2] = 16'h0202;
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h4242;
        tick();
        chk("stray_fill_done", 32'(bus.done), 32'b0100);
        chk("stray_fill_rdata", 32'(bus.rdata), 16'h4242);
        bus.mem_rdata = 16'h9999;
        bus.fill_req  = '0;
        tick();
        chk("stray_resp_done", 32'(bus.done), 0);
        chk("stray_resp_req", 32'(bus.mem_req), 0);
        chk("stray_resp_rdata", 32'(bus.rdata), 16'h4242);
        bus.mem_ack = 1'b0;
        tick();
        chk("stray_after_done", 32'(bus.done), 0);
        chk("stray_after_rdata", 32'(bus.rdata), 16'h4242);

        // Random traffic against a transaction-level model of the arbiter.
        do_reset();
        auto_mem    = 1'b0;
        m_rr        = 0;
        m_win       = 0;
        m_spill     = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        m_fill_val  = '0;
        m_rdata     = '0;
        m_free_at   = 0;
        m_busy_from = -10;
        m_busy_to   = -11;
        m_done_at   = -10;
        for (int c = 0; c < 600; c++) begin
            in_busy = (c >= m_busy_from) && (c <= m_busy_to);
            chk("rnd_mem_req", 32'(bus.mem_req), 32'(in_busy));
            if (in_busy) begin
                chk("rnd_mem_we", 32'(bus.mem_we), 32'(m_spill));
                chk("rnd_mem_addr", 32'(bus.mem_addr), 32'(m_addr));
                if (m_spill) chk("rnd_mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
            end
            if (c == m_done_at && !m_spill) m_rdata = m_fill_val;
            chk("rnd_done", 32'(bus.done), (c == m_done_at) ? (32'd1 << m_win) : 32'd0);
            chk("rnd_done_is_fill", 32'(bus.done_is_fill), 32'(c == m_done_at && !m_spill));
            chk("rnd_rdata", 32'(bus.rdata), 32'(m_rdata));

            if (c == m_done_at + 1) begin
                if (m_spill) bus.spill_req[m_win] = 1'b0;
                else         bus.fill_req[m_win]  = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                if (!bus.fill_req[k] && !bus.spill_req[k] && $urandom_range(0, 5) == 0) begin
                    r                 = 2'($urandom_range(1, 3));
                    bus.req_addr[k]   = 16'($urandom_range(0, 15));
                    bus.spill_data[k] = 16'($urandom);
                    bus.spill_req[k]  = r[1];
                    bus.fill_req[k]   = r[0];
                end
            end

            if (c >= m_free_at) begin
                m_cand = bus.fill_req | bus.spill_req;
                got    = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    kk = (m_rr + j) % 4;
                    if (!got && m_cand[kk]) begin
                        got   = 1'b1;
                        m_win = kk;
                    end
                end
                if (got) begin
                    m_spill     = bus.spill_req[m_win];
                    m_addr      = bus.req_addr[m_win];
                    m_wdata     = bus.spill_data[m_win];
                    m_fill_val  = mem_read(m_addr);
                    kk          = int'($urandom_range(0, 3));
                    m_busy_from = c + 1;
                    m_busy_to   = c + 1 + kk;
                    m_done_at   = c + 2 + kk;
                    m_free_at   = c + 3 + kk;
                    m_rr        = (m_win + 1) % 4;
                end
            end

            if (c == m_busy_to) begin
                bus.mem_ack = 1'b1;
                if (m_spill) begin
                    mem_arr[m_addr] = m_wdata;
                    bus.mem_rdata   = 16'($urandom);
                end else begin
                    bus.mem_rdata = mem_read(m_addr);
                end
            end else if (c >= m_busy_from && c < m_busy_to) begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 16'($urandom);
            end else begin
                bus.mem_ack   = ($urandom_range(0, 3) == 0);
                bus.mem_rdata = 16'($urandom);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/rf_mem_arb.md
# rf_mem_arb

Memory-port arbiter for the per-core register-file cache. It shares one 16-bit data-memory port between NCORES register-file entries. Each entry can request a fill (an entry being retrieved from memory) or a spill (a dirty value written back when the entry is evicted or the core finishes). The block sits between the register file / writeback stage and data memory, and grants one access at a time in round-robin order.

## Interface
Parameters:
- NCORES, default 4, number of requesting register-file entries; must be 2 or more.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- fill_req  input  NCORES  bit k: entry k requests a read of req_addr[k].
- spill_req  input  NCORES  bit k: entry k requests a write of spill_data[k] to req_addr[k].
- req_addr  input  NCORES*16  entry k's address (tag) in bits [16k+15:16k].
- spill_data  input  NCORES*16  entry k's value to write, in bits [16k+15:16k].
- done  output  NCORES  one-cycle pulse on bit k when entry k's operation completes.
- done_is_fill  output  1  high with done when the completed operation was a fill.
- rdata  output  16  fill data; valid while done is high.
- mem_req  output  1  memory request; held high until acknowledged.
- mem_we  output  1  high for a spill (write), low for a fill (read).
- mem_addr  output  16  memory address.
- mem_wdata  output  16  write data.
- mem_ack  input  1  memory has accepted the write, or rdata is valid this cycle.
- mem_rdata  input  16  read data; sampled when mem_ack is high.

## Operation
- State machine: IDLE, BUSY, RESP.
- **IDLE**
  - Build per-entry candidates: cand[k] = fill_req[k] | spill_req[k].
  - If any candidate exists, pick the first set bit searching upward from rr_ptr, wrapping from NCORES-1 to 0.
  - Latch the winner index, op, addr and wdata into registers, then go to BUSY.
  - If there is no candidate, stay in IDLE.
- **Op choice per entry:** spill beats fill. If both bits are set, the spill is served first and the fill wins a later arbitration. This implements evict-then-refill.
- **BUSY**
  - mem_req=1; mem_we, mem_addr and mem_wdata come from the latched registers and stay stable.
  - Requester inputs are ignored in this state; changing them has no effect.
  - On mem_ack=1: capture mem_rdata into rdata (fills only; spills leave rdata unchanged), go to RESP.
- **RESP**
  - done[winner]=1 and done_is_fill is driven for exactly one cycle.
  - rr_ptr <= winner+1, wrapping at NCORES.
  - Go to IDLE.
- **Requester contract:** hold the request bit(s) and operands until done; deassert the served bit on the edge that ends the RESP cycle. A request still asserted in the following IDLE is treated as new.
- mem_ack outside BUSY is ignored.
- rr_ptr is $clog2(NCORES) bits. Its wrap is explicit, not modular overflow, so it also works for non-power-of-2 NCORES.

## Timing
- **Reset values:** state=IDLE, rr_ptr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, done_is_fill=0, rdata=0.
- **Reset mid-operation:** mem_req drops immediately (asynchronously) and any in-flight operation is abandoned with no done pulse. Memory must tolerate an abandoned request. The requester re-issues it after reset.
- **Latency:** a request seen in IDLE at cycle t gives mem_req high from t+1.
  - With mem_ack high at t+1 (zero wait): done at t+2, IDLE at t+3.
  - Each wait cycle adds one cycle.
  - Peak throughput is one operation per 3 cycles.
- mem_ack may be high in the first cycle of mem_req.
- Outputs are registered or decoded from state registers only, with no combinational path from any input to any output.
- done is one-hot or zero in every cycle.

## Test plan
- **Single fill:** NCORES=4, fill_req=0010, req_addr[1]=0x1234, memory returns 0xBEEF with zero wait.
  - Required: mem_req/mem_addr=0x1234/mem_we=0 at t+1, then done=0010, done_is_fill=1, rdata=0xBEEF at t+2.
- **Round-robin fairness:** all four fill_req held permanently, zero-wait memory.
  - Required: done order 0,1,2,3,0 with one done every 3 cycles.
  - Then release entry 3 after its done; the next sequence must be 0,1,2,0 (wrap with an empty slot).
- **Spill before fill:** entry 2 asserts spill_req and fill_req with addr 0x0040 and spill_data 0x00AA.
  - Required: a write of 0x00AA to 0x0040 first (done_is_fill=0).
  - Then a read of 0x0040 returning the new memory value, done_is_fill=1.
- **Wait states / stability:** mem_ack delayed 5 cycles while the requester changes spill_data and other entries raise requests.
  - Required: mem_addr/mem_wdata/mem_we constant for all 6 BUSY cycles.
  - Exactly one done, for the original entry.
- **Reset mid-BUSY:** assert rst during the 3rd wait cycle of a fill.
  - Required: mem_req=0 in the same cycle as rst without waiting for a clock edge, no done pulse, rr_ptr=0.
  - After release, a pending entry 3 plus entry 0 request are served 0 first.
- **Stray ack:** mem_ack pulsed high in IDLE and in RESP.
  - Required: no state change, rdata unchanged, no extra done.
